// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and an optional
// 2-entry skid buffer that keeps in_ready_o off the downstream ready path.
//
//  state    | meaning
//  ---------+-------------------------------------------
//  ST_EMPTY | no payload held (occ 0)
//  ST_FULL  | payload in main register (occ 1)
//  ST_SKID  | main and skid registers both held (occ 2)
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter bit                SKID_EN   = 1'b1,
  parameter bit                FLUSH_CLR = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  output logic [1:0]        occ_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              in_fire, out_fire;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_data_o  = main_q;
  assign occ_o       = state_q;
  // Without the skid entry, ready must look through to downstream to keep 1/cycle.
  assign in_ready_o  = SKID_EN ? ready_q : (!out_valid_o || out_ready_i);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      if (FLUSH_CLR) begin
        main_d = RESET_VAL;
        skid_d = RESET_VAL;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_data_i;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire && SKID_EN) begin
            state_d = ST_SKID;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_SKID);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector and scoreboard bench for pipe_stage_reg in three configurations
// (skid/no-clear, skid/clear-on-flush, no-skid) sharing one input stimulus.
module tb_pipe_stage_reg;
  localparam int W = 16;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         out_ready_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [W-1:0] in_data_i = '0;

  logic         a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [W-1:0] a_out_data, b_out_data, c_out_data;
  logic [1:0]   a_occ, b_occ, c_occ;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(16'h5A5A), .SKID_EN(1'b1), .FLUSH_CLR(1'b0)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(a_in_ready),
    .in_data_i(in_data_i), .out_valid_o(a_out_valid), .out_ready_i(out_ready_i),
    .out_data_o(a_out_data), .flush_i(flush_i), .occ_o(a_occ));

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(16'hDEAD), .SKID_EN(1'b1), .FLUSH_CLR(1'b1)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(b_in_ready),
    .in_data_i(in_data_i), .out_valid_o(b_out_valid), .out_ready_i(out_ready_i),
    .out_data_o(b_out_data), .flush_i(flush_i), .occ_o(b_occ));

  pipe_stage_reg #(.DATA_W(W), .RESET_VAL(16'h0000), .SKID_EN(1'b0), .FLUSH_CLR(1'b0)) u_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(c_in_ready),
    .in_data_i(in_data_i), .out_valid_o(c_out_valid), .out_ready_i(out_ready_i),
    .out_data_o(c_out_data), .flush_i(flush_i), .occ_o(c_occ));

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         fl;
    logic         ev;
    logic [W-1:0] ed;
    logic [1:0]   eo;
    logic         er;
  } vec_t;

  vec_t vecs[16];
  logic [W-1:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
    @(negedge clk_i);
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0; in_data_i = '0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] seq;
    logic         in_fire, out_fire;

    //                iv    d       ordy  fl    ev    ed      eo    er
    vecs[0]  = '{1'b1, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0001, 2'd1, 1'b1};
    vecs[1]  = '{1'b1, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0002, 2'd1, 1'b1};
    vecs[2]  = '{1'b1, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0003, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0003, 2'd0, 1'b1};
    vecs[4]  = '{1'b1, 16'h000A, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd1, 1'b1};
    vecs[5]  = '{1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0};
    vecs[6]  = '{1'b1, 16'h000F, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000B, 2'd1, 1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h000B, 2'd0, 1'b1};
    vecs[9]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd1, 1'b1};
    vecs[10] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd2, 1'b0};
    vecs[11] = '{1'b1, 16'h000C, 1'b0, 1'b1, 1'b0, 16'h0001, 2'd0, 1'b1};
    vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 2'd0, 1'b1};
    vecs[13] = '{1'b1, 16'h0007, 1'b1, 1'b0, 1'b1, 16'h0007, 2'd1, 1'b1};
    vecs[14] = '{1'b1, 16'h000C, 1'b1, 1'b1, 1'b0, 16'h0007, 2'd0, 1'b1};
    vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0007, 2'd0, 1'b1};

    // Reset values, held in reset
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_data", a_out_data, 16'h5A5A);
    chk("rst_a_occ", a_occ, 2'd0);
    chk("rst_a_ready", a_in_ready, 1'b1);
    chk("rst_b_data", b_out_data, 16'hDEAD);
    chk("rst_c_ready", c_in_ready, 1'b1);
    rst_ni = 1'b1;

    // Streaming, skid fill/drain and flush on the skid/no-clear instance
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      tick();
      chk($sformatf("vec%0d_valid", i), a_out_valid, vecs[i].ev);
      chk($sformatf("vec%0d_data", i), a_out_data, vecs[i].ed);
      chk($sformatf("vec%0d_occ", i), a_occ, vecs[i].eo);
      chk($sformatf("vec%0d_ready", i), a_in_ready, vecs[i].er);
    end

    // Flush clears payload only when FLUSH_CLR=1
    do_reset();
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    tick();
    chk("fclr_b_load", b_out_data, 16'h1234);
    chk("fclr_b_valid", b_out_valid, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    chk("fclr_b_valid_after", b_out_valid, 1'b0);
    chk("fclr_b_data_after", b_out_data, 16'hDEAD);
    chk("fclr_b_occ_after", b_occ, 2'd0);
    chk("fkeep_a_data_after", a_out_data, 16'h1234);
    chk("fkeep_a_valid_after", a_out_valid, 1'b0);

    // No-skid instance: combinational ready
    do_reset();
    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    #1 chk("c_ready_empty", c_in_ready, 1'b1);
    tick();
    chk("c_load_data", c_out_data, 16'h0011);
    chk("c_load_occ", c_occ, 2'd1);
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    #1 chk("c_ready_stall", c_in_ready, 1'b0);
    tick();
    chk("c_hold_data", c_out_data, 16'h0011);
    @(negedge clk_i);
    out_ready_i = 1'b1;
    #1 chk("c_ready_go", c_in_ready, 1'b1);
    tick();
    chk("c_pass1_data", c_out_data, 16'h0022);
    drive(1'b1, 16'h0033, 1'b1, 1'b0);
    #1 chk("c_ready_stream", c_in_ready, 1'b1);
    tick();
    chk("c_pass2_data", c_out_data, 16'h0033);
    chk("c_pass2_occ", c_occ, 2'd1);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    chk("c_drain_valid", c_out_valid, 1'b0);

    // Async reset while two entries are held
    do_reset();
    drive(1'b1, 16'h00A1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h00A2, 1'b0, 1'b0);
    tick();
    chk("arst_pre_occ", a_occ, 2'd2);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 1'b0);
    chk("arst_occ", a_occ, 2'd0);
    chk("arst_data", a_out_data, 16'h5A5A);
    chk("arst_ready", a_in_ready, 1'b1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random stall scoreboard on the skid instance
    seq = 16'h0100;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk_i);
      in_valid_i  = 1'($urandom_range(0, 1));
      in_data_i   = seq;
      out_ready_i = ($urandom_range(0, 2) != 0);
      #1;
      in_fire  = in_valid_i && a_in_ready;
      out_fire = a_out_valid && out_ready_i;
      if (out_fire) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_order", a_out_data, sb_q.pop_front());
      end
      if (in_fire) begin
        sb_q.push_back(seq);
        seq = seq + 16'd1;
      end
      tick();
      chk("sb_occ", a_occ, sb_q.size());
    end
    in_valid_i = 1'b0;
    for (int cyc = 0; cyc < 10 && sb_q.size() != 0; cyc++) begin
      @(negedge clk_i);
      out_ready_i = 1'b1;
      #1;
      if (a_out_valid) chk("sb_drain_order", a_out_data, sb_q.pop_front());
    end
    chk("sb_drain_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
